alu_result_fifo: RTL and testbench

Downstream stage of the 4-bit ALU. Captures each ALU result with its opcode and operands, derives status flags, and buffers result and flags in a small FIFO. The FIFO is drained through a valid/ready port toward the output/serializer logic. It decouples the ALU's one-result-per-cycle rate from a slower consumer and records lost results.

---
 rtl/alu_result_fifo.sv | 102 ++++++++++
 tb/tb_alu_result_fifo.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// Result/flag FIFO behind the 4-bit ALU: tags each accepted result with status flags
// and buffers it for a slower valid/ready consumer, flagging results lost while full.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_result,
  input  logic [1:0]    in_op,
  input  logic [3:0]    in_a,
  input  logic [3:0]    in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic [3:0]    out_flags,
  output logic [CW-1:0] count,
  output logic          ovr,
  input  logic          clr_ovr
);

  localparam int AW = CW - 1;

  logic [CW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] rptr_q, rptr_d;
  logic          ovr_q, ovr_d;
  logic [11:0]   mem_q [DEPTH];

  logic          full, empty, push, pop;
  logic          flag_z, flag_b, flag_o, flag_d;
  logic [7:0]    wr_data;
  logic [11:0]   wr_entry;
  logic [11:0]   head_entry;

  // The extra pointer MSB distinguishes full from empty when the index bits match.
  always_comb begin
    empty = (wptr_q == rptr_q);
    full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[CW-1] != rptr_q[CW-1]);
    push  = in_valid && !full;
    pop   = !empty && out_ready;
  end

  always_comb begin
    flag_d   = (in_op == 2'b11) && (in_b == 4'd0);
    flag_b   = (in_op == 2'b10) && (in_a < in_b);
    flag_o   = ((in_op == 2'b00) || (in_op == 2'b01)) && (in_result[7:4] != 4'd0);
    wr_data  = flag_d ? 8'hFF : in_result;
    flag_z   = (wr_data == 8'd0);
    wr_entry = {flag_d, flag_o, flag_b, flag_z, wr_data};
  end

  // A new overrun in the same cycle as clr_ovr keeps ovr set.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovr_d  = ovr_q;
    if (push) begin
      wptr_d = wptr_q + CW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + CW'(1);
    end
    if (clr_ovr) begin
      ovr_d = 1'b0;
    end
    if (in_valid && full) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovr_q  <= ovr_d;
    end
  end

  // Storage is deliberately not reset; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wptr_q[AW-1:0]] <= wr_entry;
    end
  end

  always_comb begin
    head_entry = mem_q[rptr_q[AW-1:0]];
    in_ready   = !full;
    out_valid  = !empty;
    out_data   = empty ? 8'd0 : head_entry[7:0];
    out_flags  = empty ? 4'd0 : head_entry[11:8];
    count      = wptr_q - rptr_q;
    ovr        = ovr_q;
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo: expected {flags,data} entries are queued when a push
// is accepted and compared against the head output whenever the consumer pops.
module tb_alu_result_fifo;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_result = 8'd0;
  logic [1:0]    in_op = 2'd0;
  logic [3:0]    in_a = 4'd0;
  logic [3:0]    in_b = 4'd0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [7:0]    out_data;
  logic [3:0]    out_flags;
  logic [CW-1:0] count;
  logic          ovr;
  logic          clr_ovr = 1'b0;

  int            total = 0;
  int            bad = 0;
  int            pops_seen = 0;
  logic [11:0]   sb[$];
  logic          exp_ovr = 1'b0;

  alu_result_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags),
    .count(count), .ovr(ovr), .clr_ovr(clr_ovr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected entry as {D,O,B,Z,data}.
  function automatic logic [11:0] model(input logic [1:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic [7:0] res);
    logic d, o, bf, z;
    logic [7:0] data;
    d    = (op == 2'b11) && (b == 4'd0);
    bf   = (op == 2'b10) && (a < b);
    o    = (op == 2'b00 || op == 2'b01) && (res[7:4] != 4'd0);
    data = d ? 8'hFF : res;
    z    = (data == 8'd0);
    return {d, o, bf, z, data};
  endfunction

  // One clock: drive inputs, check against the model, advance, update the model.
  task automatic tick(input logic iv, input logic [7:0] res, input logic [1:0] op,
                      input logic [3:0] a, input logic [3:0] b,
                      input logic ordy, input logic clr);
    logic do_pop, do_push, ovr_evt;
    logic [11:0] e;
    in_valid  = iv;
    in_result = res;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    clr_ovr   = clr;
    if (!rst) begin
      total++;
      if (count !== CW'(sb.size())) begin
        bad++; $display("[TB] FAIL count: got %0d want %0d", count, sb.size());
      end
      total++;
      if (in_ready !== (sb.size() != DEPTH)) begin
        bad++; $display("[TB] FAIL in_ready: got %b want %b", in_ready, sb.size() != DEPTH);
      end
      total++;
      if (out_valid !== (sb.size() != 0)) begin
        bad++; $display("[TB] FAIL out_valid: got %b want %b", out_valid, sb.size() != 0);
      end
      total++;
      if (ovr !== exp_ovr) begin
        bad++; $display("[TB] FAIL ovr: got %b want %b", ovr, exp_ovr);
      end
    end
    do_pop  = !rst && (sb.size() != 0) && ordy;
    do_push = !rst && iv && (sb.size() < DEPTH);
    ovr_evt = !rst && iv && (sb.size() == DEPTH);
    if (do_pop) begin
      e = sb.pop_front();
      pops_seen++;
      total++;
      if ({out_flags, out_data} !== e) begin
        bad++; $display("[TB] FAIL pop_entry: got %h want %h", {out_flags, out_data}, e);
      end
    end else if (!rst && sb.size() == 0) begin
      total++;
      if ({out_flags, out_data} !== 12'h000) begin
        bad++; $display("[TB] FAIL empty_gate: got %h want 000", {out_flags, out_data});
      end
    end
    if (do_push) sb.push_back(model(op, a, b, res));
    if (rst) begin
      sb.delete();
      exp_ovr = 1'b0;
    end else if (ovr_evt) begin
      exp_ovr = 1'b1;
    end else if (clr) begin
      exp_ovr = 1'b0;
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_ovr   = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && sb.size() != 0; i++) tick(1'b0, 8'd0, 2'd0, 4'd0, 4'd0, 1'b1, 1'b0);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL drain_empty: got %b want 0", out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(1'b0, 8'd0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    tick(1'b0, 8'd0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    total++;
    if ({out_valid, in_ready, count, ovr, out_data} !== {1'b0, 1'b1, 3'd0, 1'b0, 8'h00}) begin
      bad++; $display("[TB] FAIL reset_state: got %b%b %0d %b %h want 01 0 0 00",
                      out_valid, in_ready, count, ovr, out_data);
    end
    tick(1'b1, 8'h07, 2'b00, 4'd3, 4'd4, 1'b0, 1'b0);
    total++;
    if ({out_data, out_flags, count} !== {8'h07, 4'b0000, 3'd1}) begin
      bad++; $display("[TB] FAIL first_push: got %h %b %0d want 07 0000 1", out_data, out_flags, count);
    end
    drain();
  endtask

  task automatic test_flags();
    logic [7:0] exp_d [4];
    logic [3:0] exp_f [4];
    exp_d = '{8'hFD, 8'hE1, 8'h00, 8'hFF};
    exp_f = '{4'b0010, 4'b0100, 4'b0001, 4'b1000};
    tick(1'b1, 8'hFD, 2'b10, 4'd2, 4'd5, 1'b0, 1'b0);
    tick(1'b1, 8'hE1, 2'b01, 4'd15, 4'd15, 1'b0, 1'b0);
    tick(1'b1, 8'h00, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0);
    tick(1'b1, 8'h3C, 2'b11, 4'd9, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({out_data, out_flags} !== {exp_d[i], exp_f[i]}) begin
        bad++; $display("[TB] FAIL flags_%0d: got %h %b want %h %b", i, out_data, out_flags, exp_d[i], exp_f[i]);
      end
      tick(1'b0, 8'd0, 2'd0, 4'd0, 4'd0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_fill_overrun();
    for (int i = 0; i < DEPTH; i++) tick(1'b1, 8'h10 + 8'(i), 2'b10, 4'd5, 4'd1, 1'b0, 1'b0);
    total++;
    if ({count, in_ready} !== {3'd4, 1'b0}) begin
      bad++; $display("[TB] FAIL full_state: got %0d %b want 4 0", count, in_ready);
    end
    tick(1'b1, 8'h99, 2'b10, 4'd5, 4'd1, 1'b0, 1'b0);
    total++;
    if ({ovr, count} !== {1'b1, 3'd4}) begin
      bad++; $display("[TB] FAIL overrun: got %b %0d want 1 4", ovr, count);
    end
    tick(1'b1, 8'h98, 2'b10, 4'd5, 4'd1, 1'b0, 1'b1);
    total++;
    if (ovr !== 1'b1) begin
      bad++; $display("[TB] FAIL set_wins: got %b want 1", ovr);
    end
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (out_data !== 8'h10 + 8'(i)) begin
        bad++; $display("[TB] FAIL drain_order_%0d: got %h want %h", i, out_data, 8'h10 + 8'(i));
      end
      tick(1'b0, 8'd0, 2'd0, 4'd0, 4'd0, 1'b1, 1'b0);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL no_fifth: got %b want 0", out_valid);
    end
    tick(1'b0, 8'd0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    total++;
    if (ovr !== 1'b0) begin
      bad++; $display("[TB] FAIL clr_ovr: got %b want 0", ovr);
    end
  endtask

  task automatic test_simultaneous();
    tick(1'b1, 8'h20, 2'b10, 4'd5, 4'd1, 1'b0, 1'b0);
    tick(1'b1, 8'h21, 2'b10, 4'd5, 4'd1, 1'b0, 1'b0);
    tick(1'b1, 8'h22, 2'b10, 4'd5, 4'd1, 1'b1, 1'b0);
    total++;
    if ({count, out_data} !== {3'd2, 8'h21}) begin
      bad++; $display("[TB] FAIL mid_push_pop: got %0d %h want 2 21", count, out_data);
    end
    tick(1'b1, 8'h23, 2'b10, 4'd5, 4'd1, 1'b0, 1'b0);
    tick(1'b1, 8'h24, 2'b10, 4'd5, 4'd1, 1'b0, 1'b0);
    tick(1'b1, 8'h25, 2'b10, 4'd5, 4'd1, 1'b1, 1'b0);
    total++;
    if ({count, in_ready, out_data} !== {3'd3, 1'b1, 8'h22}) begin
      bad++; $display("[TB] FAIL full_push_pop: got %0d %b %h want 3 1 22", count, in_ready, out_data);
    end
    tick(1'b0, 8'd0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    drain();
  endtask

  task automatic test_back_to_back();
    int sent;
    int start_pops;
    sent = 0;
    start_pops = pops_seen;
    for (int cyc = 0; cyc < 200 && (sent < 40 || sb.size() != 0); cyc++) begin
      if (sent < 40 && sb.size() < DEPTH) begin
        tick(1'b1, 8'(sent), 2'b00, 4'(sent), 4'd0, ((cyc / 3) % 2) == 1, 1'b0);
        sent++;
      end else begin
        tick(1'b0, 8'd0, 2'd0, 4'd0, 4'd0, ((cyc / 3) % 2) == 1, 1'b0);
      end
    end
    total++;
    if (pops_seen - start_pops !== 40) begin
      bad++; $display("[TB] FAIL stream_count: got %0d want 40", pops_seen - start_pops);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) tick(1'b1, 8'h30 + 8'(i), 2'b10, 4'd5, 4'd1, 1'b0, 1'b0);
    rst = 1'b1;
    tick(1'b1, 8'h77, 2'b10, 4'd5, 4'd1, 1'b1, 1'b0);
    rst = 1'b0;
    total++;
    if ({count, out_valid} !== {3'd0, 1'b0}) begin
      bad++; $display("[TB] FAIL mid_reset: got %0d %b want 0 0", count, out_valid);
    end
    tick(1'b1, 8'h5A, 2'b10, 4'd5, 4'd1, 1'b0, 1'b0);
    tick(1'b1, 8'h5B, 2'b10, 4'd5, 4'd1, 1'b0, 1'b0);
    total++;
    if (out_data !== 8'h5A) begin
      bad++; $display("[TB] FAIL post_reset_head: got %h want 5a", out_data);
    end
    drain();
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_flags();
    test_fill_overrun();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
